// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC peripheral bus: region map, slave indices,
// response-mux state encoding and the default error read data.
package soc_bus_pkg;

  localparam logic [3:0]  REGION_MEM  = 4'h0;
  localparam logic [3:0]  REGION_GPIO = 4'h4;
  localparam logic [3:0]  REGION_UART = 4'h5;
  localparam logic [3:0]  REGION_I2C  = 4'h6;

  localparam int          SLV_IDX_W = 2;
  localparam logic [1:0]  SLV_MEM  = 2'd0;
  localparam logic [1:0]  SLV_GPIO = 2'd1;
  localparam logic [1:0]  SLV_UART = 2'd2;
  localparam logic [1:0]  SLV_I2C  = 2'd3;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2,
    ST_RESP   = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic                 hit;
    logic [SLV_IDX_W-1:0] idx;
  } region_dec_t;

  // Map the top address nibble to a slave index; hit=0 marks a hole in the map.
  function automatic region_dec_t decode_region(input logic [3:0] nib);
    region_dec_t d;
    d.hit = 1'b1;
    d.idx = SLV_MEM;
    case (nib)
      REGION_MEM:  d.idx = SLV_MEM;
      REGION_GPIO: d.idx = SLV_GPIO;
      REGION_UART: d.idx = SLV_UART;
      REGION_I2C:  d.idx = SLV_I2C;
      default:     d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the limit-th enabled cycle is reached. limit=0 never expires.
module bus_timeout_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // Count enabled cycles; cleared whenever no transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + W'(1);
  end

  // count holds the number of earlier enabled cycles, so the limit-th
  // cycle is the one where count == limit-1.
  assign expired = (limit != '0) && (count == limit - W'(1));

endmodule

// File: rtl/bus_response_mux.sv
// CPU-facing end of the peripheral bus: decodes the request to one of four
// slaves, forwards it, and returns the slave response or a bus error.
module bus_response_mux
  import soc_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT,
  parameter int          NUM_SLAVES     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_valid,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic                     bus_err,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [7:0]               err_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  bus_state_e           state, state_nxt;
  region_dec_t          dec;
  logic [SLV_IDX_W-1:0] sel_idx;
  logic                 sel_ready;
  logic [31:0]          sel_rdata;
  logic                 expired;

  assign dec       = decode_region(m_addr[31:28]);
  assign sel_ready = s_ready[sel_idx];
  assign sel_rdata = s_rdata[32*int'(sel_idx) +: 32];

  bus_timeout_counter #(.W(CNT_W)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_ACTIVE),
    .enable  (state == ST_ACTIVE),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state; a ready in the expiry cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (m_valid) state_nxt = dec.hit ? ST_ACTIVE : ST_ERR;
      ST_ACTIVE: begin
        if (sel_ready)    state_nxt = ST_RESP;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_ERR:    state_nxt = ST_IDLE;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, response data capture and error bookkeeping. The slave
  // side is only loaded for mapped requests, so unmapped write data never
  // reaches a slave.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_idx   <= SLV_MEM;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      m_rdata   <= '0;
      err_count <= '0;
    end else begin
      if (state == ST_IDLE && m_valid && dec.hit) begin
        sel_idx <= dec.idx;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
      end
      if (state == ST_ACTIVE && sel_ready) m_rdata <= sel_rdata;
      if (state_nxt == ST_ERR)             m_rdata <= ERR_DATA;
      if (state == ST_ERR && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // One-hot slave valid while a transaction is in flight.
  always_comb begin
    s_valid = '0;
    if (state == ST_ACTIVE) s_valid[sel_idx] = 1'b1;
  end

  assign m_ready = (state == ST_RESP) || (state == ST_ERR);
  assign bus_err = (state == ST_ERR);

endmodule

// File: tb/tb_bus_response_mux.sv
// Directed bench for bus_response_mux with a 16-cycle timeout.
module tb_bus_response_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_valid;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready, bus_err;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;

  bus_response_mux #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .bus_err(bus_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_valid = 1'b1; m_addr = a; m_wdata = d; m_wstrb = s;
  endtask

  initial begin
    rst = 1'b1; m_valid = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; s_rdata = '0;
    tick(); tick();
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_err_cnt", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();

    // mem read, ready 3 cycles after s_valid; m_valid held through m_ready
    req(32'h0000_0010, 32'h0, 4'h0);
    tick();                                   // T1
    chk("mem_s_valid", 32'(s_valid), 32'h1);
    chk("mem_s_addr", s_addr, 32'h0000_0010);
    tick(); tick(); tick();                   // T4
    chk("mem_no_early_rdy", 32'(m_ready), 32'd0);
    s_ready = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
    tick();                                   // T5
    s_ready = '0;
    chk("mem_m_ready", 32'(m_ready), 32'd1);
    chk("mem_m_rdata", m_rdata, 32'h1234_5678);
    chk("mem_bus_err", 32'(bus_err), 32'd0);
    chk("mem_s_valid_clr", 32'(s_valid), 32'd0);
    tick();                                   // m_valid ignored during m_ready
    chk("mem_pulse_one", 32'(m_ready), 32'd0);
    chk("mem_no_reaccept", 32'(s_valid), 32'd0);
    m_valid = 0;
    tick();                                   // IDLE; response data held
    chk("mem_rdata_hold", m_rdata, 32'h1234_5678);

    // gpio write, slave side stable until ready
    req(32'h4000_0004, 32'h0000_00A5, 4'b0001);
    tick();
    m_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("gpio_s_valid", 32'(s_valid), 32'h2);
      chk("gpio_s_wdata", s_wdata, 32'h0000_00A5);
      chk("gpio_s_wstrb", 32'(s_wstrb), 32'h1);
      if (i == 2) begin s_ready = 4'b0010; s_rdata[63:32] = 32'h0BAD_0001; end
      tick();
    end
    s_ready = '0;
    chk("gpio_m_ready", 32'(m_ready), 32'd1);
    chk("gpio_bus_err", 32'(bus_err), 32'd0);
    tick();

    // unmapped access
    req(32'h1000_0000, 32'h1111_1111, 4'hF);
    tick();                                   // T1
    m_valid = 0;
    chk("unm_s_valid", 32'(s_valid), 32'd0);
    chk("unm_m_ready", 32'(m_ready), 32'd1);
    chk("unm_bus_err", 32'(bus_err), 32'd1);
    chk("unm_m_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("unm_err_cnt0", 32'(err_count), 32'd0);
    tick();
    chk("unm_err_cnt1", 32'(err_count), 32'd1);
    chk("unm_no_fwd", s_wdata, 32'h0000_00A5);
    chk("unm_pulse_one", 32'(bus_err), 32'd0);

    // uart timeout: no ready for 16 cycles
    req(32'h5000_0100, 32'h0, 4'h0);
    tick();                                   // T1
    m_valid = 0;
    for (int i = 0; i < 15; i++) tick();      // T16
    chk("tmo_s_valid16", 32'(s_valid), 32'h4);
    chk("tmo_no_rdy16", 32'(m_ready), 32'd0);
    tick();                                   // T17
    chk("tmo_s_valid_drop", 32'(s_valid), 32'd0);
    chk("tmo_m_ready", 32'(m_ready), 32'd1);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_m_rdata", m_rdata, 32'hDEAD_BEEF);
    tick();
    chk("tmo_err_cnt", 32'(err_count), 32'd2);

    // uart with ready exactly on cycle 16: normal completion
    req(32'h5000_0100, 32'h0, 4'h0);
    tick();
    m_valid = 0;
    for (int i = 0; i < 15; i++) tick();      // T16
    s_ready = 4'b0100; s_rdata[95:64] = 32'h7777_0016;
    tick();                                   // T17
    s_ready = '0;
    chk("tmo16_m_ready", 32'(m_ready), 32'd1);
    chk("tmo16_bus_err", 32'(bus_err), 32'd0);
    chk("tmo16_m_rdata", m_rdata, 32'h7777_0016);
    tick();
    chk("tmo16_err_cnt", 32'(err_count), 32'd2);

    // i2c with spurious ready from mem and gpio
    s_rdata = {32'hCAFE_F00D, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    req(32'h6000_0020, 32'h0, 4'h0);
    tick();
    m_valid = 0;
    chk("i2c_s_valid", 32'(s_valid), 32'h8);
    for (int i = 0; i < 3; i++) begin
      s_ready = (i[0]) ? 4'b0010 : 4'b0101;
      tick();
      chk("i2c_spurious", 32'(m_ready), 32'd0);
    end
    s_ready = 4'b1011;
    tick();
    s_ready = '0;
    chk("i2c_m_ready", 32'(m_ready), 32'd1);
    chk("i2c_m_rdata", m_rdata, 32'hCAFE_F00D);
    tick();

    // reset during an active mem access
    req(32'h0000_0040, 32'h5555_AAAA, 4'hF);
    tick(); tick();
    chk("rmid_active", 32'(s_valid), 32'h1);
    rst = 1'b1; m_valid = 0;
    tick();
    rst = 1'b0;
    chk("rmid_s_valid", 32'(s_valid), 32'd0);
    chk("rmid_m_ready", 32'(m_ready), 32'd0);
    chk("rmid_s_addr", s_addr, 32'd0);
    chk("rmid_s_wdata", s_wdata, 32'd0);
    chk("rmid_s_wstrb", 32'(s_wstrb), 32'd0);
    chk("rmid_m_rdata", m_rdata, 32'd0);
    chk("rmid_err_cnt", 32'(err_count), 32'd0);
    s_ready = 4'b0001;                        // stale ready in IDLE is ignored
    tick();
    chk("rmid_no_pulse", 32'(m_ready), 32'd0);
    s_ready = '0;
    tick();
    s_rdata[31:0] = 32'h0F0F_1234;
    req(32'h0000_0080, 32'h0, 4'h0);
    tick();
    m_valid = 0;
    chk("fresh_s_valid", 32'(s_valid), 32'h1);
    s_ready = 4'b0001;
    tick();
    s_ready = '0;
    chk("fresh_m_ready", 32'(m_ready), 32'd1);
    chk("fresh_m_rdata", m_rdata, 32'h0F0F_1234);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
